// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the signed seven-segment scan display.
// Segment codes are raw active-high {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_MINUS = 7'h40;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // Widened to 5 bits so that -8 negates to +8 instead of wrapping.
  function automatic logic [3:0] abs4(input logic signed [3:0] v);
    logic signed [4:0] w;
    w = {v[3], v};
    if (w < 0) w = -w;
    return w[3:0];
  endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational magnitude (0-8) to raw active-high segment code; anything else is blank.
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic [3:0]       mag_i,
  output logic [SEG_W-1:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (mag_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_signed_scan.sv
// Two-digit multiplexed display of a signed 4-bit value: digit 0 magnitude, digit 1 sign.
// The value is latched once per frame so sign and magnitude never disagree.
module seg7_signed_scan
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic signed [3:0] value_i,
  output logic [SEG_W-1:0]  seg_o,
  output logic [1:0]        an_o,
  output logic              frame_done_o
);

  localparam int unsigned       CntW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0]   LastCnt  = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0]   BlankCnt = CntW'(BLANK_CYCLES);
  localparam logic [SEG_W-1:0]  SegOff   = {SEG_W{SEG_ACTIVE_LOW}};
  localparam logic [1:0]        AnOff    = {2{AN_ACTIVE_LOW}};

  if (REFRESH_DIV < 2 || BLANK_CYCLES >= REFRESH_DIV) begin : g_param_err
    $error("seg7_signed_scan: need REFRESH_DIV >= 2 and BLANK_CYCLES < REFRESH_DIV");
  end

  logic [CntW-1:0]   div_cnt_q, div_cnt_d;
  logic              dig_q, dig_d;
  logic signed [3:0] held_q, held_d;
  logic              frame_done_d;
  logic [SEG_W-1:0]  seg_d;
  logic [1:0]        an_d;
  logic [SEG_W-1:0]  mag_code;
  logic [SEG_W-1:0]  seg_raw;
  logic [1:0]        an_raw;

  seg7_digit_decode u_decode (
    .mag_i (abs4(held_q)),
    .seg_o (mag_code)
  );

  always_comb begin
    div_cnt_d    = div_cnt_q + CntW'(1);
    dig_d        = dig_q;
    held_d       = held_q;
    frame_done_d = 1'b0;
    if (div_cnt_q == LastCnt) begin
      div_cnt_d = '0;
      dig_d     = ~dig_q;
      // Latch only at the sign-to-magnitude boundary so a frame shows one value.
      if (dig_q) begin
        held_d       = value_i;
        frame_done_d = 1'b1;
      end
    end
  end

  always_comb begin
    seg_raw = SEG_BLANK;
    an_raw  = 2'b00;
    if (div_cnt_q >= BlankCnt) begin
      an_raw[dig_q] = 1'b1;
      if (dig_q) seg_raw = held_q[3] ? SEG_MINUS : SEG_BLANK;
      else       seg_raw = mag_code;
    end
    seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    an_d  = AN_ACTIVE_LOW ? ~an_raw : an_raw;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt_q    <= '0;
      dig_q        <= 1'b0;
      held_q       <= '0;
      frame_done_o <= 1'b0;
      seg_o        <= SegOff;
      an_o         <= AnOff;
    end else begin
      div_cnt_q    <= div_cnt_d;
      dig_q        <= dig_d;
      held_q       <= held_d;
      frame_done_o <= frame_done_d;
      seg_o        <= seg_d;
      an_o         <= an_d;
    end
  end

endmodule

// File: tb/tb_seg7_signed_scan.sv
// Directed bench for seg7_signed_scan with REFRESH_DIV=8, BLANK_CYCLES=2, active-low outputs.
module tb_seg7_signed_scan;

  logic              clk = 1'b0;
  logic              clk_en = 1'b0;
  logic              rst = 1'b0;
  logic signed [3:0] value = 4'sd0;
  logic [6:0]        seg;
  logic [1:0]        an;
  logic              frame_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Active-low codes for magnitudes 0..8.
  logic [6:0] low_code [0:8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};

  always #5 clk = clk_en & ~clk;

  seg7_signed_scan #(
    .REFRESH_DIV    (8),
    .BLANK_CYCLES   (2),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .value_i      (value),
    .seg_o        (seg),
    .an_o         (an),
    .frame_done_o (frame_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int sx4(logic [3:0] v);
    return v[3] ? int'(v) - 16 : int'(v);
  endfunction

  // Expected outputs after edge n (n counted from reset release), for latched value held.
  function automatic logic [6:0] exp_seg(int n, int held);
    int p, d, m;
    p = (n - 1) % 8;
    d = ((n - 1) / 8) % 2;
    if (p < 2) return 7'h7F;
    if (d == 1) return (held < 0) ? 7'h3F : 7'h7F;
    m = (held < 0) ? -held : held;
    return low_code[m];
  endfunction

  function automatic logic [1:0] exp_an(int n);
    int p, d;
    p = (n - 1) % 8;
    d = ((n - 1) / 8) % 2;
    if (p < 2) return 2'b11;
    return (d == 1) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [9:0] exp_all(int n, int held);
    return {exp_seg(n, held), exp_an(n), (n % 16) == 0};
  endfunction

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({seg, an, frame_done} !== {7'h7F, 2'b11, 1'b0}) begin
      errors++;
      $display("FAIL reset_async: got seg=%h an=%b fd=%b, want seg=7f an=11 fd=0", seg, an,
               frame_done);
    end
    clk_en = 1'b1;
    repeat (3) tick();
    checks++;
    if ({seg, an, frame_done} !== {7'h7F, 2'b11, 1'b0}) begin
      errors++;
      $display("FAIL reset_held: got seg=%h an=%b fd=%b, want seg=7f an=11 fd=0", seg, an,
               frame_done);
    end
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_first_frame();
    value = 4'sd5;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if ({seg, an, frame_done} !== exp_all(cyc, 0)) begin
        errors++;
        $display("FAIL first_frame cyc=%0d: got {seg,an,fd}=%h want %h", cyc,
                 {seg, an, frame_done}, exp_all(cyc, 0));
      end
    end
  endtask

  task automatic test_positive();
    value = -4'sd8;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if ({seg, an, frame_done} !== exp_all(cyc, 5)) begin
        errors++;
        $display("FAIL positive cyc=%0d: got {seg,an,fd}=%h want %h", cyc,
                 {seg, an, frame_done}, exp_all(cyc, 5));
      end
    end
  endtask

  task automatic test_most_negative();
    value = -4'sd3;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if ({seg, an, frame_done} !== exp_all(cyc, -8)) begin
        errors++;
        $display("FAIL most_negative cyc=%0d: got {seg,an,fd}=%h want %h", cyc,
                 {seg, an, frame_done}, exp_all(cyc, -8));
      end
    end
  endtask

  task automatic test_no_tearing();
    for (int i = 0; i < 16; i++) begin
      tick();
      if (cyc == 60) value = 4'sd2;
      checks++;
      if ({seg, an, frame_done} !== exp_all(cyc, -3)) begin
        errors++;
        $display("FAIL no_tearing cyc=%0d: got {seg,an,fd}=%h want %h", cyc,
                 {seg, an, frame_done}, exp_all(cyc, -3));
      end
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if ({seg, an, frame_done} !== exp_all(cyc, 2)) begin
        errors++;
        $display("FAIL after_tear cyc=%0d: got {seg,an,fd}=%h want %h", cyc,
                 {seg, an, frame_done}, exp_all(cyc, 2));
      end
    end
  endtask

  task automatic test_periodic();
    int pulses = 0;
    int last = -1;
    for (int i = 0; i < 64; i++) begin
      tick();
      checks++;
      if ((an == 2'b11) !== (((cyc - 1) % 8) < 2) || an === 2'b00) begin
        errors++;
        $display("FAIL blanking cyc=%0d: got an=%b", cyc, an);
      end
      if (frame_done === 1'b1) begin
        pulses++;
        if (last >= 0) begin
          checks++;
          if (cyc - last !== 16) begin
            errors++;
            $display("FAIL pulse_spacing: got %0d want 16", cyc - last);
          end
        end
        last = cyc;
      end
    end
    checks++;
    if (pulses !== 4) begin
      errors++;
      $display("FAIL pulse_count: got %0d want 4", pulses);
    end
  endtask

  task automatic test_upstream_drive();
    int shown = 2;
    for (int s = 0; s < 18; s++) begin
      value = 4'(s);
      for (int i = 0; i < 16; i++) begin
        tick();
        checks++;
        if ({seg, an, frame_done} !== exp_all(cyc, shown)) begin
          errors++;
          $display("FAIL upstream step=%0d cyc=%0d: got {seg,an,fd}=%h want %h", s, cyc,
                   {seg, an, frame_done}, exp_all(cyc, shown));
        end
      end
      shown = sx4(4'(s));
    end
  endtask

  task automatic test_mid_slot_reset();
    value = -4'sd1;
    for (int i = 0; i < 27; i++) begin
      tick();
      checks++;
      if ({seg, an, frame_done} !== exp_all(cyc, (i < 16) ? 1 : -1)) begin
        errors++;
        $display("FAIL pre_reset cyc=%0d: got {seg,an,fd}=%h want %h", cyc,
                 {seg, an, frame_done}, exp_all(cyc, (i < 16) ? 1 : -1));
      end
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({seg, an, frame_done} !== {7'h7F, 2'b11, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: got seg=%h an=%b fd=%b, want seg=7f an=11 fd=0", seg, an,
               frame_done);
    end
    repeat (2) tick();
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      checks++;
      if ({seg, an, frame_done} !== exp_all(cyc, (i < 16) ? 0 : -1)) begin
        errors++;
        $display("FAIL post_reset cyc=%0d: got {seg,an,fd}=%h want %h", cyc,
                 {seg, an, frame_done}, exp_all(cyc, (i < 16) ? 0 : -1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_positive();
    test_most_negative();
    test_no_tearing();
    test_periodic();
    test_upstream_drive();
    test_mid_slot_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
